fmul_arbiter: RTL and testbench
===============================

# fmul_arbiter

Shares one combinational FP32 multiplier (`fmul`) among `N_REQ` independent requesters. Each requester has a valid/ready operand channel and a valid/ready result channel. The block grants the multiplier round-robin, registers operands and results around `fmul`, and routes each product back to the requester that issued it. It sits between the FPU's issue logic and the `fmul` datapath. It is the only instance of `fmul` in the FPU cluster.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default `$clog2(N_REQ)`: requester-index width. Derived; do not override.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  N_REQ  per-requester operand valid.
- `req_ready`  out  N_REQ  per-requester operand accept; at most one bit high per cycle.
- `req_a`  in  N_REQ*32  packed operand A; requester i uses bits [32i+31:32i].
- `req_b`  in  N_REQ*32  packed operand B, same packing as `req_a`.
- `rsp_valid`  out  N_REQ  per-requester result valid.
- `rsp_ready`  in  N_REQ  per-requester result accept.
- `rsp_data`  out  N_REQ*32  packed FP32 products, same packing as `req_a`.
- `busy`  out  N_REQ  requester i has an operation outstanding (debug/status).

## Operation
- Credit: each requester may have at most one outstanding operation.
  - `busy[i]` sets when requester i's operands are accepted.
  - `busy[i]` clears when requester i's result handshake completes (`rsp_valid[i] & rsp_ready[i]`).
- Eligibility: `elig = req_valid & ~busy`, using the registered `busy` only.
- Grant: round-robin over `elig`, starting at pointer `rr_ptr`.
  - `req_ready = grant` (one-hot or zero).
  - `req_ready` may depend on `req_valid`. It never depends on `rsp_ready`.
- Pointer: on any grant to index g, `rr_ptr <= (g+1) mod N_REQ`. With no grant, `rr_ptr` holds.
- Stage S1 (operand register): on a grant, loads `s1_valid=1`, `s1_id=g`, and that requester's A and B. Otherwise `s1_valid=0`.
- `fmul` computes combinationally from the S1 operands.
- Stage S2 (per-requester result register): when `s1_valid`, loads `rsp_data[s1_id]` with the `fmul` output and sets `rsp_valid[s1_id]=1`.
  - `rsp_valid[i]` and `rsp_data[i]` hold stable until `rsp_ready[i]`.
  - The result slot for i can never be occupied when a new result for i arrives, because of the credit rule.
- `fmul` results pass through unmodified, including NaN (canonical `0x7FC00000`), ±inf, signed zero and denormals.
- Requesters that are not granted may change operands freely. Operands are sampled only on the handshake cycle.

## Timing
- Reset values: `req_ready` is combinational and is 0 while `busy` is all-ones or `req_valid` is 0. After reset `busy=0`, so `req_ready` follows `elig`.
  - All registers reset to 0: `rsp_valid=0`, `rsp_data=0`, `busy=0`, `rr_ptr=0`, `s1_valid=0`.
- Latency: operand handshake at cycle c gives `rsp_valid[i]=1` from cycle c+2.
- Per-requester rate:
  - Result accepted at cycle c+2 clears `busy` at the edge ending c+2.
  - The earliest re-grant is cycle c+3, so one operation per 3 cycles per requester.
- Aggregate rate: one grant per cycle when at least 3 requesters are active.
- Simultaneous events:
  - A result handshake and a new `req_valid` from the same requester in the same cycle: no grant that cycle (busy is still set).
  - A new result landing in slot j while slot i handshakes: independent, no interaction.
- Asynchronous reset mid-operation drops all in-flight operations and results. No stale `rsp_valid` after reset deasserts.

## Structure
- Shared package `fpu_pkg` holds:
  - `FP32_W = 32`
  - `FP32_QNAN = 32'h7FC00000`
  - `FP32_PINF` and `FP32_NINF`
  - a `fp32_t` typedef
- One sub-module, `rr_arbiter`:
  - parameter `N`; inputs `elig` and `ptr`; outputs one-hot `grant` and `grant_idx`.
  - Purely combinational, so it can be reused by future FPU schedulers.
- `fmul` is instantiated once inside `fmul_arbiter`.

## Test plan
- **Single op:** requester 0 sends A=`0x40000000`, B=`0x40400000` at cycle 0.
  - Expect `rsp_valid[0]` at cycle 2 with `0x40C00000`, and `busy[0]` high during cycles 1–2.
- **Contention:** all 4 `req_valid` high at cycle 0 with `rr_ptr=0`.
  - Expect grants to 0, 1, 2, 3 on cycles 0–3 and `rsp_valid` to rise on cycles 2–5, each with the correct product.
- **Backpressure:** hold `rsp_ready[1]=0` for 10 cycles.
  - Expect `rsp_data[1]` stable, `req_ready[1]=0` throughout, and requesters 0/2 still completing.
  - After release, requester 1 is re-granted one cycle after its handshake.
- **Specials:** route inf×0 (`0x7F800000`,`0x00000000`), -0×2 (`0x80000000`,`0x40000000`) and denormal×1 (`0x00000001`,`0x3F800000`).
  - Expect `0x7FC00000`, `0x80000000` and `0x00000001` respectively.
- **Fairness:** requesters 0 and 2 continuously valid, with `rsp_ready` always 1.
  - Expect grants to alternate 0, 2, 0, 2 and no requester starved for more than N_REQ cycles.
- **Reset mid-op:** assert `rst_n=0` for 1 cycle, one cycle after granting requester 3.
  - Expect no `rsp_valid[3]`, `busy=0`, and `rr_ptr=0` after reset.

Source files
------------

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FP32 constants and types for the FPU cluster
// Purpose: FP32 width, canonical quiet NaN, signed infinities and the
//          fp32_t word type used by fmul and fmul_arbiter.
// Ports:   none (package).
package fpu_pkg;

   localparam int FP32_W = 32;

   typedef logic [FP32_W-1:0] fp32_t;

   localparam fp32_t FP32_QNAN = 32'h7FC00000;
   localparam fp32_t FP32_PINF = 32'h7F800000;
   localparam fp32_t FP32_NINF = 32'hFF800000;

endpackage

// File: rtl/fmul.sv
// rtl/fmul.sv - combinational IEEE-754 FP32 multiplier, round-to-nearest-even
// Purpose: y = a * b. NaN results are canonical quiet NaN; infinities,
//          signed zeros and denormal inputs/outputs are handled fully.
// Ports:   a  in  32  operand A
//          b  in  32  operand B
//          y  out 32  product
module fmul
   import fpu_pkg::*;
(
   input  logic [FP32_W-1:0] a,
   input  logic [FP32_W-1:0] b,
   output logic [FP32_W-1:0] y
);

   logic        sy;
   logic [7:0]  ea, eb, ea_eff, eb_eff;
   logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic [23:0] sig_a, sig_b;
   logic [47:0] prod, pn;
   logic [5:0]  k, sh;
   logic signed [11:0] e_norm, den_sh, e_fin;
   logic [95:0] wide;
   logic [23:0] frac24;
   logic        guard, sticky, round_up;
   logic [24:0] rnd;

   function automatic logic [5:0] msb_pos(input logic [47:0] v);
      msb_pos = '0;
      for (int i = 0; i < 48; i++) begin
         if (v[i]) msb_pos = 6'(i);
      end
   endfunction

   assign sy     = a[31] ^ b[31];
   assign ea     = a[30:23];
   assign eb     = b[30:23];
   assign a_zero = (ea == 8'd0)   && (a[22:0] == 23'd0);
   assign b_zero = (eb == 8'd0)   && (b[22:0] == 23'd0);
   assign a_inf  = (ea == 8'hFF)  && (a[22:0] == 23'd0);
   assign b_inf  = (eb == 8'hFF)  && (b[22:0] == 23'd0);
   assign a_nan  = (ea == 8'hFF)  && (a[22:0] != 23'd0);
   assign b_nan  = (eb == 8'hFF)  && (b[22:0] != 23'd0);

   // Denormals use exponent 1 with no hidden bit.
   assign ea_eff = (ea == 8'd0) ? 8'd1 : ea;
   assign eb_eff = (eb == 8'd0) ? 8'd1 : eb;
   assign sig_a  = {(ea != 8'd0), a[22:0]};
   assign sig_b  = {(eb != 8'd0), b[22:0]};
   assign prod   = {24'd0, sig_a} * {24'd0, sig_b};
   assign k      = msb_pos(prod);

   // Biased exponent once the product's leading one is treated as the hidden
   // bit: k + ea + eb - 2*127 - 46 + 127.
   assign e_norm = $signed({6'd0, k}) + $signed({4'd0, ea_eff})
                 + $signed({4'd0, eb_eff}) - 12'sd173;
   assign den_sh = 12'sd1 - e_norm;
   assign pn     = prod << (6'd47 - k);

   always_comb begin
      sh = 6'd0;
      // Tiny results shift right into the denormal range; beyond 50 places
      // everything is sticky anyway.
      if (e_norm < 12'sd1) begin
         if (den_sh > 12'sd50) sh = 6'd50;
         else                  sh = den_sh[5:0];
      end
   end

   assign wide     = {pn, 48'd0} >> sh;
   assign frac24   = wide[95:72];
   assign guard    = wide[71];
   assign sticky   = |wide[70:0];
   assign round_up = guard & (sticky | frac24[0]);
   assign rnd      = {1'b0, frac24} + {24'd0, round_up};
   // Rounding carry only occurs when rnd == 2^24, so rnd[22:0] is already 0.
   assign e_fin    = e_norm + $signed({11'd0, rnd[24]});

   always_comb begin
      y = '0;
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
         y = FP32_QNAN;
      end else if (a_inf || b_inf) begin
         y = sy ? FP32_NINF : FP32_PINF;
      end else if (a_zero || b_zero) begin
         y = {sy, 31'd0};
      end else if (e_norm >= 12'sd1) begin
         if (e_fin >= 12'sd255) y = sy ? FP32_NINF : FP32_PINF;
         else                   y = {sy, e_fin[7:0], rnd[22:0]};
      end else begin
         // Denormal; a round-up into bit 23 yields the smallest normal.
         y = {sy, 7'd0, rnd[23], rnd[22:0]};
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
// Purpose: picks the first eligible index at or after ptr (wrapping).
// Ports:   elig      in  N     eligible requesters
//          ptr       in  ID_W  highest-priority index this cycle
//          grant     out N     one-hot grant, zero when nothing is eligible
//          grant_idx out ID_W  binary index of grant (0 when no grant)
module rr_arbiter #(
   parameter int N    = 4,
   parameter int ID_W = $clog2(N)
) (
   input  logic [N-1:0]    elig,
   input  logic [ID_W-1:0] ptr,
   output logic [N-1:0]    grant,
   output logic [ID_W-1:0] grant_idx
);

   logic            found;
   logic [ID_W-1:0] idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      // Walk from ptr upward; the first eligible index seen wins.
      for (int j = 0; j < N; j++) begin
         idx = ID_W'((32'(ptr) + 32'(j)) % N);
         if (!found && elig[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = idx;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fmul_arbiter.sv
// rtl/fmul_arbiter.sv - round-robin sharing of one fmul among N_REQ requesters
// Purpose: one outstanding op per requester, round-robin grant, operand
//          register (S1) before fmul, per-requester result register (S2).
// Ports:   clk, rst_n               clock, async active-low reset
//          req_valid/req_ready      per-requester operand handshake
//          req_a/req_b              packed operands, 32 bits per requester
//          rsp_valid/rsp_ready      per-requester result handshake
//          rsp_data                 packed products, 32 bits per requester
//          busy                     requester has an op outstanding
module fmul_arbiter
   import fpu_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [N_REQ*FP32_W-1:0] req_a,
   input  logic [N_REQ*FP32_W-1:0] req_b,
   output logic [N_REQ-1:0]        rsp_valid,
   input  logic [N_REQ-1:0]        rsp_ready,
   output logic [N_REQ*FP32_W-1:0] rsp_data,
   output logic [N_REQ-1:0]        busy
);

   logic [N_REQ-1:0]        elig, grant;
   logic [ID_W-1:0]         grant_idx;
   fp32_t                   fmul_y;

   logic [N_REQ-1:0]        busy_q, busy_d;
   logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
   logic                    s1_valid_q, s1_valid_d;
   logic [ID_W-1:0]         s1_id_q, s1_id_d;
   fp32_t                   s1_a_q, s1_a_d, s1_b_q, s1_b_d;
   logic [N_REQ-1:0]        rsp_valid_q, rsp_valid_d;
   logic [N_REQ*FP32_W-1:0] rsp_data_q, rsp_data_d;

   // Registered busy gates eligibility, so a requester whose result is
   // handshaking this cycle is not re-granted until the next one.
   assign elig = req_valid & ~busy_q;

   rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_rr (
      .elig      (elig),
      .ptr       (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   fmul u_fmul (
      .a (s1_a_q),
      .b (s1_b_q),
      .y (fmul_y)
   );

   always_comb begin
      busy_d     = (busy_q | grant) & ~(rsp_valid_q & rsp_ready);
      rr_ptr_d   = rr_ptr_q;
      s1_valid_d = |grant;
      s1_id_d    = s1_id_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      if (|grant) begin
         rr_ptr_d = (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + ID_W'(1);
         s1_id_d  = grant_idx;
         s1_a_d   = req_a[FP32_W*grant_idx +: FP32_W];
         s1_b_d   = req_b[FP32_W*grant_idx +: FP32_W];
      end

      // The credit rule guarantees slot s1_id_q is empty when its result lands.
      rsp_valid_d = rsp_valid_q & ~rsp_ready;
      rsp_data_d  = rsp_data_q;
      if (s1_valid_q) begin
         rsp_valid_d[s1_id_q]                    = 1'b1;
         rsp_data_d[FP32_W*s1_id_q +: FP32_W]    = fmul_y;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q      <= '0;
         rr_ptr_q    <= '0;
         s1_valid_q  <= 1'b0;
         s1_id_q     <= '0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
      end else begin
         busy_q      <= busy_d;
         rr_ptr_q    <= rr_ptr_d;
         s1_valid_q  <= s1_valid_d;
         s1_id_q     <= s1_id_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign req_ready = grant;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_fmul_arbiter.sv
// tb/tb_fmul_arbiter.sv - directed self-checking bench for fmul_arbiter
module tb_fmul_arbiter;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   req_valid, req_ready, rsp_valid, rsp_ready, busy;
   logic [127:0] req_a, req_b, rsp_data;

   int checks   = 0;
   int failures = 0;
   int done0, done2;
   logic [3:0] fair_exp [3];

   always #5 clk = ~clk;

   fmul_arbiter #(.N_REQ(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
   endtask

   function automatic logic [31:0] dslot(input int i);
      return rsp_data[32*i +: 32];
   endfunction

   task automatic apply_reset;
      rst_n     = 1'b0;
      req_valid = '0;
      cyc;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = '0;
      req_a     = '0;
      req_b     = '0;
      fair_exp  = '{4'b0001, 4'b0100, 4'b0000};
      cyc; cyc;
      settle;
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_busy",      32'(busy),      32'h0);
      check("rst_rsp_data0", dslot(0),       32'h0);
      check("rst_rsp_data3", dslot(3),       32'h0);
      check("rst_req_ready", 32'(req_ready), 32'h0);
      rst_n = 1'b1;

      // Single op: 2.0 * 3.0
      cyc;
      rsp_ready = 4'hF;
      req_valid = 4'b0001;
      set_op(0, 32'h40000000, 32'h40400000);
      settle;
      check("single_ready_c0", 32'(req_ready), 32'h1);
      cyc;
      req_valid = '0;
      settle;
      check("single_busy_c1",  32'(busy),      32'h1);
      check("single_rspv_c1",  32'(rsp_valid), 32'h0);
      cyc; settle;
      check("single_rspv_c2",  32'(rsp_valid), 32'h1);
      check("single_data_c2",  dslot(0),       32'h40C00000);
      check("single_busy_c2",  32'(busy),      32'h1);
      cyc; settle;
      check("single_busy_c3",  32'(busy),      32'h0);
      check("single_rspv_c3",  32'(rsp_valid), 32'h0);

      // Contention: all four valid, pointer at 0
      apply_reset;
      cyc;
      req_valid = 4'hF;
      set_op(0, 32'h3F800000, 32'h40000000);
      set_op(1, 32'h40000000, 32'h40000000);
      set_op(2, 32'h40400000, 32'h40000000);
      set_op(3, 32'h40800000, 32'h40000000);
      settle;
      check("cont_ready_c0", 32'(req_ready), 32'b0001);
      cyc; settle;
      check("cont_ready_c1", 32'(req_ready), 32'b0010);
      cyc; settle;
      check("cont_ready_c2", 32'(req_ready), 32'b0100);
      check("cont_rspv_c2",  32'(rsp_valid), 32'b0001);
      check("cont_data0",    dslot(0),       32'h40000000);
      cyc; settle;
      check("cont_ready_c3", 32'(req_ready), 32'b1000);
      check("cont_rspv_c3",  32'(rsp_valid), 32'b0010);
      check("cont_data1",    dslot(1),       32'h40800000);
      cyc;
      req_valid = '0;
      settle;
      check("cont_rspv_c4",  32'(rsp_valid), 32'b0100);
      check("cont_data2",    dslot(2),       32'h40C00000);
      cyc; settle;
      check("cont_rspv_c5",  32'(rsp_valid), 32'b1000);
      check("cont_data3",    dslot(3),       32'h41000000);
      cyc; settle;
      check("cont_busy_end", 32'(busy),      32'h0);

      // Backpressure on requester 1 (pointer is 0 again here)
      cyc;
      rsp_ready = 4'b1101;
      req_valid = 4'b0010;
      set_op(1, 32'h40400000, 32'h40400000);
      settle;
      check("bp_ready_c0", 32'(req_ready), 32'b0010);
      cyc;
      req_valid = 4'b0111;
      set_op(0, 32'h40000000, 32'h40000000);
      set_op(2, 32'h3F800000, 32'h3F800000);
      set_op(1, 32'h12345678, 32'h9ABCDEF0);
      done0 = 0;
      done2 = 0;
      for (int k = 0; k < 10; k++) begin
         if (k > 0) cyc;
         settle;
         check("bp_ready1_low", 32'(req_ready[1]), 32'h0);
         if (k > 0) begin
            check("bp_rspv1_held", 32'(rsp_valid[1]), 32'h1);
            check("bp_data1_held", dslot(1),          32'h41100000);
         end
         if (rsp_valid[0]) begin
            done0++;
            check("bp_data0", dslot(0), 32'h40800000);
         end
         if (rsp_valid[2]) begin
            done2++;
            check("bp_data2", dslot(2), 32'h3F800000);
         end
      end
      check("bp_done0", 32'(done0), 32'd3);
      check("bp_done2", 32'(done2), 32'd3);
      cyc;
      rsp_ready = 4'hF;
      req_valid = 4'b0010;
      set_op(1, 32'h40800000, 32'h3F000000);
      settle;
      check("bp_rel_same_cycle_ready", 32'(req_ready), 32'h0);
      check("bp_rel_rspv1",            32'(rsp_valid[1]), 32'h1);
      cyc; settle;
      check("bp_regrant", 32'(req_ready), 32'b0010);
      cyc;
      req_valid = '0;
      settle;
      check("bp_new_rspv1_c1", 32'(rsp_valid[1]), 32'h0);
      cyc; settle;
      check("bp_new_rspv1_c2", 32'(rsp_valid[1]), 32'h1);
      check("bp_new_data1",    dslot(1),          32'h40000000);

      // Special operands, results held with rsp_ready low
      cyc; cyc;
      rsp_ready = '0;
      req_valid = 4'hF;
      set_op(0, 32'h7F800000, 32'h00000000);
      set_op(1, 32'h80000000, 32'h40000000);
      set_op(2, 32'h7F7FFFFF, 32'h40000000);
      set_op(3, 32'h00000001, 32'h3F800000);
      repeat (6) cyc;
      settle;
      check("spec_rspv",      32'(rsp_valid), 32'hF);
      check("spec_inf_x_0",   dslot(0),       32'h7FC00000);
      check("spec_nzero_x_2", dslot(1),       32'h80000000);
      check("spec_overflow",  dslot(2),       32'h7F800000);
      check("spec_denorm",    dslot(3),       32'h00000001);
      req_valid = '0;
      rsp_ready = 4'hF;
      cyc; settle;
      check("spec_drain_rspv", 32'(rsp_valid), 32'h0);
      check("spec_drain_busy", 32'(busy),      32'h0);

      // Fairness between requesters 0 and 2
      apply_reset;
      cyc;
      rsp_ready = 4'hF;
      req_valid = 4'b0101;
      set_op(0, 32'h3F800000, 32'h3F800000);
      set_op(2, 32'h40000000, 32'h40000000);
      for (int k = 0; k < 12; k++) begin
         settle;
         check("fair_grant", 32'(req_ready), 32'(fair_exp[k % 3]));
         cyc;
      end
      req_valid = '0;
      cyc; cyc; cyc;

      // Reset one cycle after granting requester 3
      apply_reset;
      cyc;
      req_valid = 4'b1000;
      set_op(3, 32'h40000000, 32'h40000000);
      settle;
      check("rmo_grant3", 32'(req_ready), 32'b1000);
      cyc;
      req_valid = '0;
      rst_n     = 1'b0;
      settle;
      check("rmo_busy_in_reset", 32'(busy), 32'h0);
      cyc;
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         settle;
         check("rmo_no_rspv", 32'(rsp_valid), 32'h0);
         check("rmo_busy",    32'(busy),      32'h0);
         cyc;
      end
      req_valid = 4'hF;
      settle;
      check("rmo_ptr_zero", 32'(req_ready), 32'b0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
